wb_dmem_responder: RTL and testbench
====================================

Name: wb_dmem_responder

Overview:
- Memory-side responder for the data-cache line-fill and write-back protocol.
- Accepts line read (allocate) and line write (write-back) requests from the dcache controller and returns a single-cycle ack.
- Models a narrow memory bus: configurable access latency, then beat-serialised transfer, with full-line storage behind it.
- Used as the dmem end in cache/victim-cache subsystem benches and as the FPGA-side line memory.

Parameters:
- ADDR_WIDTH, 32, request byte-address width.
- LINE_WIDTH, 128, cache line width in bits.
- BUS_WIDTH, 32, memory beat width; LINE_WIDTH must be an integer multiple of it. BEATS = LINE_WIDTH/BUS_WIDTH.
- MEM_LINES, 256, number of lines stored (power of 2).
- RD_LATENCY, 4, wait cycles before read beats (0 allowed).
- WR_LATENCY, 2, wait cycles before write beats (0 allowed).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- dcache2mem_req_i  in  1  request; held high until ack.
- dcache2mem_wr_i  in  1  1 = write-back, 0 = line read.
- dcache2mem_kill_i  in  1  abort the current request.
- dcache2mem_addr_i  in  ADDR_WIDTH  line address (offset bits ignored).
- dcache2mem_data_i  in  LINE_WIDTH  write-back line data.
- mem2dcache_ack_o  out  1  one-cycle completion pulse.
- mem2dcache_data_o  out  LINE_WIDTH  read line data.
- rd_cnt_o  out  32  completed reads (optional feature).
- wr_cnt_o  out  32  completed writes (optional feature).
- kill_cnt_o  out  32  aborted requests (optional feature).

Behaviour:
- Reset values: mem2dcache_ack_o=0, mem2dcache_data_o=0, all counters 0, FSM in IDLE, beat and latency counters 0. Storage contents are not reset.
- Line index = addr[OFF+log2(MEM_LINES)-1:OFF], where OFF = log2(LINE_WIDTH/8). Upper bits are ignored, so addresses alias modulo MEM_LINES.
- FSM states: IDLE, WAIT, XFER, RESP.
- IDLE:
  - If req=1 and kill=0, capture addr, wr and data (writes only), load the latency counter with RD_LATENCY or WR_LATENCY, and go to WAIT.
  - If the latency is 0, go directly to XFER.
  - kill in IDLE has no effect.
- WAIT: decrement the latency counter; go to XFER when it reaches 0.
- XFER: one beat per cycle, beat counter 0..BEATS-1.
  - Read: beat k copies storage bits [k*BUS_WIDTH +: BUS_WIDTH] into a line shadow register.
  - Write: beat k copies the same slice of the captured data into a write shadow register.
  - After the last beat, go to RESP.
- RESP:
  - Assert ack for exactly this cycle.
  - Read: mem2dcache_data_o <= read shadow.
  - Write: commit the write shadow to storage as a whole line.
  - Return to IDLE.
- Latency from the request-accept edge to the ack cycle: LAT + BEATS + 1 cycles. With defaults, read = 9 and write = 7.
- req in the RESP cycle is ignored. A request still held high is accepted in the following IDLE cycle; this covers back-to-back write-back then allocate.
- mem2dcache_data_o changes only on a read ack and holds between read acks.
- Abort: kill=1, or req=0, in WAIT, XFER or RESP-entry:
  - Return to IDLE next cycle with no ack and no storage change.
  - A partially written line is never committed.
  - kill takes precedence over completion in the same cycle.
- The write-commit storage port is single-port. Read beats never coincide with a commit because requests are serialised.
- Reset mid-operation: the transaction is discarded and storage is unchanged.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined:
  - rd_cnt_o / wr_cnt_o increment on each read / write ack.
  - kill_cnt_o increments on each abort of a non-IDLE transaction.
  - Counters saturate at 2^32-1.
- Undefined: the counters and their logic are absent, and the three ports are tied to 0.

Test Plan:
- Write addr 0x0000_0040, data 0x0123_4567_89AB_CDEF_0011_2233_4455_6677, req held high → ack exactly 7 cycles after accept, one cycle wide; counter wr_cnt_o=1.
- Read addr 0x0000_0040 → ack at +9 cycles; mem2dcache_data_o equals the written line and holds after ack drops.
- Write the new line 0xFFFF…FFFF to 0x40, assert kill during XFER beat 2 → no ack; FSM back in IDLE; a following read returns the old line; kill_cnt_o=1.
- Write-back to 0x80 with req kept high through the ack cycle and wr switched to 0 with addr 0x40 → exactly one write ack, then a read accepted the cycle after RESP; read ack 9 cycles later with line 0x40 data.
- Assert rst during WAIT of a read → ack stays 0, data output 0, next request completes normally.
- With MEM_LINES=256, write addr 0x0000_1040 then read 0x0000_0040 → same line returned (alias).

Source files
------------

// File: rtl/wb_dmem_responder.sv
// Line-granular data-memory responder for dcache fill/write-back: latency wait, beat-serialised transfer, single-cycle ack.
// Optional performance counters are enabled with `define DMEM_PERF_CNT_EN.
module wb_dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned MEM_LINES  = 256,
  parameter int unsigned RD_LATENCY = 4,
  parameter int unsigned WR_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dcache2mem_req_i,
  input  logic                  dcache2mem_wr_i,
  input  logic                  dcache2mem_kill_i,
  input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
  input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
  output logic                  mem2dcache_ack_o,
  output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o,
  output logic [31:0]           kill_cnt_o
);

  localparam int unsigned BEATS   = LINE_WIDTH / BUS_WIDTH;
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF     = $clog2(LINE_WIDTH / 8);
  localparam int unsigned IDX_W   = $clog2(MEM_LINES);
  localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned LAT_W   = ($clog2(MAX_LAT + 1) < 1) ? 1 : $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} state_e;

  state_e                state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  wr_q, wr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] rd_sh_q, rd_sh_d;
  logic [LINE_WIDTH-1:0] wr_sh_q, wr_sh_d;
  logic                  ack_q, ack_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic                  commit_c;
  logic                  abort_c;
  logic [LAT_W-1:0]      lat_sel;
  logic [31:0]           slice_lo;

  logic [LINE_WIDTH-1:0] mem_q [MEM_LINES];

  // Offset and aliased upper address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^dcache2mem_addr_i;

  assign lat_sel  = dcache2mem_wr_i ? LAT_W'(WR_LATENCY) : LAT_W'(RD_LATENCY);
  assign slice_lo = 32'(beat_q) * BUS_WIDTH;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rd_sh_d  = rd_sh_q;
    wr_sh_d  = wr_sh_q;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    commit_c = 1'b0;
    abort_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dcache2mem_req_i && !dcache2mem_kill_i) begin
          wr_d   = dcache2mem_wr_i;
          idx_d  = dcache2mem_addr_i[OFF +: IDX_W];
          lat_d  = lat_sel;
          beat_d = '0;
          if (dcache2mem_wr_i) wdata_d = dcache2mem_data_i;
          state_d = (lat_sel == '0) ? XFER : WAIT;
        end
      end
      WAIT: begin
        if (dcache2mem_kill_i || !dcache2mem_req_i) begin
          abort_c = 1'b1;
          lat_d   = '0;
          state_d = IDLE;
        end else if (lat_q <= LAT_W'(1)) begin
          lat_d   = '0;
          state_d = XFER;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      XFER: begin
        if (dcache2mem_kill_i || !dcache2mem_req_i) begin
          abort_c = 1'b1;
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          if (wr_q) wr_sh_d[slice_lo +: BUS_WIDTH] = wdata_q[slice_lo +: BUS_WIDTH];
          else      rd_sh_d[slice_lo +: BUS_WIDTH] = mem_q[idx_q][slice_lo +: BUS_WIDTH];
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = RESP;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        // An abort arriving in the response cycle still wins over completion.
        if (dcache2mem_kill_i || !dcache2mem_req_i) begin
          abort_c = 1'b1;
        end else begin
          ack_d = 1'b1;
          if (wr_q) commit_c = 1'b1;
          else      rdata_d  = rd_sh_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_sh_q <= '0;
      wr_sh_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rd_sh_q <= rd_sh_d;
      wr_sh_q <= wr_sh_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Line storage: single write port, contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_c) mem_q[idx_q] <= wr_sh_q;
  end

  assign mem2dcache_ack_o  = ack_q;
  assign mem2dcache_data_o = rdata_q;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, kill_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      kill_cnt_q <= '0;
    end else begin
      if (ack_d && !wr_q && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (ack_d && wr_q && (wr_cnt_q != '1))  wr_cnt_q <= wr_cnt_q + 32'd1;
      if (abort_c && (kill_cnt_q != '1))      kill_cnt_q <= kill_cnt_q + 32'd1;
    end
  end

  assign rd_cnt_o   = rd_cnt_q;
  assign wr_cnt_o   = wr_cnt_q;
  assign kill_cnt_o = kill_cnt_q;
`else
  assign rd_cnt_o   = '0;
  assign wr_cnt_o   = '0;
  assign kill_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_dmem_responder.sv
// Directed table-driven bench for wb_dmem_responder with hand-written back-to-back and reset sequences.
module tb_wb_dmem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         req, wr, kill;
  logic [31:0]  addr;
  logic [127:0] wdata;
  logic         ack;
  logic [127:0] rdata;
  logic [31:0]  rd_cnt, wr_cnt, kill_cnt;

  int errors = 0;
  int checks = 0;

`ifdef DMEM_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [127:0] L1   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] L2   = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
  localparam logic [127:0] L3   = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
  localparam logic [127:0] L4   = 128'hA5A5_5A5A_C3C3_3C3C_F00F_0FF0_1357_2468;
  localparam logic [127:0] ONES = {128{1'b1}};

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
    int           kill_at;   // negedge index after accept at which kill is raised, -1 none
    int           exp_lat;   // cycles from accept edge to ack, -1 = no ack
    logic [127:0] exp_data;  // data output expected after the transaction
    int           rc, wc, kc;
  } txn_t;

  txn_t tbl [12];

  wb_dmem_responder dut (
    .clk               (clk),
    .rst               (rst),
    .dcache2mem_req_i  (req),
    .dcache2mem_wr_i   (wr),
    .dcache2mem_kill_i (kill),
    .dcache2mem_addr_i (addr),
    .dcache2mem_data_i (wdata),
    .mem2dcache_ack_o  (ack),
    .mem2dcache_data_o (rdata),
    .rd_cnt_o          (rd_cnt),
    .wr_cnt_o          (wr_cnt),
    .kill_cnt_o        (kill_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_cnts(input string name, input int rc, input int wc, input int kc);
    check_int({name, " rd_cnt"},   int'(rd_cnt),   PERF ? rc : 0);
    check_int({name, " wr_cnt"},   int'(wr_cnt),   PERF ? wc : 0);
    check_int({name, " kill_cnt"}, int'(kill_cnt), PERF ? kc : 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input string name, input txn_t t);
    int n;
    bit got;
    req = 1'b1; wr = t.wr; addr = t.addr; wdata = t.wdata; kill = 1'b0;
    n = -1; got = 1'b0;
    while (n < 14 && !got) begin
      @(negedge clk);
      n++;
      if (ack) got = 1'b1;
      else if (n == t.kill_at) kill = 1'b1;
      else if (t.kill_at >= 0 && n == t.kill_at + 1) begin
        req = 1'b0; kill = 1'b0;
      end
    end
    req = 1'b0; kill = 1'b0;
    check_int({name, " ack latency"}, got ? n : -1, t.exp_lat);
    @(negedge clk);
    check_int({name, " ack width"}, int'(ack), 0);
    check_vec({name, " data"}, rdata, t.exp_data);
    check_cnts(name, t.rc, t.wc, t.kc);
  endtask

  initial begin
    txn_t t;
    int n;
    bit got;

    tbl[0]  = '{1'b1, 32'h0000_0040, L1,   -1, 7,  128'h0, 0, 1, 0};
    tbl[1]  = '{1'b0, 32'h0000_0040, '0,   -1, 9,  L1,     1, 1, 0};
    tbl[2]  = '{1'b1, 32'h0000_0040, ONES,  4, -1, L1,     1, 1, 1};
    tbl[3]  = '{1'b0, 32'h0000_0040, '0,   -1, 9,  L1,     2, 1, 1};
    tbl[4]  = '{1'b1, 32'h0000_1040, L2,   -1, 7,  L1,     2, 2, 1};
    tbl[5]  = '{1'b0, 32'h0000_0040, '0,   -1, 9,  L2,     3, 2, 1};
    tbl[6]  = '{1'b1, 32'h0000_0080, L3,   -1, 7,  L2,     3, 3, 1};
    tbl[7]  = '{1'b0, 32'h0000_0080, '0,   -1, 9,  L3,     4, 3, 1};
    tbl[8]  = '{1'b0, 32'h0000_0040, '0,    1, -1, L3,     4, 3, 2};
    tbl[9]  = '{1'b1, 32'h0000_0080, ONES,  6, -1, L3,     4, 3, 3};
    tbl[10] = '{1'b0, 32'h0000_0080, '0,   -1, 9,  L3,     5, 3, 3};
    tbl[11] = '{1'b0, 32'hFFFF_1040, '0,   -1, 9,  L2,     6, 3, 3};

    rst = 1'b1; req = 1'b0; wr = 1'b0; kill = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check_int("reset ack", int'(ack), 0);
    check_vec("reset data", rdata, 128'h0);
    check_cnts("reset", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Write-back then allocate with req held through the ack cycle.
    req = 1'b1; wr = 1'b1; addr = 32'h0000_0080; wdata = L4; kill = 1'b0;
    n = -1; got = 1'b0;
    while (n < 14 && !got) begin
      @(negedge clk);
      n++;
      if (ack) got = 1'b1;
    end
    check_int("b2b write latency", got ? n : -1, 7);
    wr = 1'b0; addr = 32'h0000_0040; wdata = '0;
    n = -1; got = 1'b0;
    while (n < 14 && !got) begin
      @(negedge clk);
      n++;
      if (ack) got = 1'b1;
    end
    req = 1'b0;
    check_int("b2b read latency", got ? n : -1, 9);
    check_vec("b2b read data", rdata, L2);
    check_cnts("b2b", 7, 4, 3);
    @(negedge clk);
    check_int("b2b ack width", int'(ack), 0);
    check_vec("b2b data hold", rdata, L2);

    t = '{1'b0, 32'h0000_0080, '0, -1, 9, L4, 8, 4, 3};
    run_txn("b2b commit", t);

    // Reset while a read sits in its latency wait.
    req = 1'b1; wr = 1'b0; addr = 32'h0000_0040;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_int("midrst ack", int'(ack), 0);
    check_vec("midrst data", rdata, 128'h0);
    rst = 1'b0; req = 1'b0;
    repeat (3) @(negedge clk);
    check_int("postrst ack", int'(ack), 0);
    check_cnts("postrst", 0, 0, 0);
    t = '{1'b0, 32'h0000_0040, '0, -1, 9, L2, 1, 0, 0};
    run_txn("postrst read", t);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
